hack_alu_mul_ctrl: RTL and testbench
====================================

# hack_alu_mul_ctrl

Multi-cycle shift-and-add multiplier controller that time-shares one external combinational 16-bit Hack ALU (`alu`). It accepts operand pairs on a valid/ready handshake, issues one ALU control word per cycle, and returns the low 16 bits of the product together with the ALU's `zr`/`ng` flags for that result. It sits beside the datapath ALU, so multiply never needs a second adder.

## Interface

**Parameters**
- `N_BITS`, default 16: number of low bits of `b` processed, legal range 1..16. Bits of `b` above `N_BITS-1` are masked to 0 at accept.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller idle and able to accept.
- `a` in 16: multiplicand.
- `b` in 16: multiplier.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `product` out 16: `(a*b) mod 2^16`, two's-complement wrap.
- `zr` out 1: 1 iff `product == 0`.
- `ng` out 1: equals `product[15]`.
- `alu_x`, `alu_y` out 16: ALU operand inputs.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no` out 1 each: ALU control inputs.
- `alu_out` in 16: ALU result.
- `alu_zr`, `alu_ng` in 1 each: ALU flags.

## Operation

**Registers**
- `acc` 16
- `mcand` 16
- `mplier` 16
- `cnt` 5
- `state` in {IDLE, STEP, FINISH, DONE}

**IDLE**
- `in_ready = 1`.
- On `in_valid && in_ready`: `acc <= 0`, `mcand <= a`, `mplier <= b & mask(N_BITS)`, `cnt <= 0`, then go to STEP.

**STEP** (one cycle per multiplier bit)
- Drive `alu_x = acc` and `alu_y = mcand`.
- Control word depends on `mplier[0]`:
  - `mplier[0] = 1`: x+y, control `zx nx zy ny f no = 000010`.
  - `mplier[0] = 0`: pass x, control `001100`.
- Edge updates: `acc <= alu_out`, `mcand <= mcand << 1` (MSB dropped), `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
- Exit to FINISH when `(mplier >> 1) == 0` or `cnt == N_BITS-1`.
- STEP always executes at least once, even when `b == 0`.

**FINISH**
- Drive `alu_x = acc`, `alu_y = 0`, control `001100`.
- Edge updates: `product <= alu_out`, `zr <= alu_zr`, `ng <= alu_ng`, then go to DONE.

**DONE**
- `out_valid = 1`.
- On `out_ready`, go to IDLE. `product`, `zr` and `ng` keep their values until the next FINISH.

**ALU drive in IDLE and DONE**
- `alu_x = 0`, `alu_y = 0`, control `101010` (constant 0).

**Handshake and boundary rules**
- `in_ready` and `out_valid` are pure decodes of `state`.
- `in_valid` is ignored outside IDLE, so no second operand is captured while busy.
- `out_valid` stays high with `product`/`zr`/`ng` stable until accepted.
- The controller cannot accept new operands in the DONE→IDLE transfer cycle.
- Overflow wraps silently with no flag.
- Signed operands give the correct low 16 bits (mod 2^16).

## Timing

**Reset**
- State goes to IDLE.
- `in_ready = 1`, `out_valid = 0`, `product = 0`, `zr = 0`, `ng = 0`.
- ALU drive takes the IDLE values.
- `acc`, `mcand`, `mplier`, `cnt` are cleared to 0.

**Reset mid-operation**
- An operation in STEP, FINISH or DONE is abandoned.
- `out_valid` is 0 from the cycle after the reset edge; no result is emitted.

**Latency**
- Let `S = min(N_BITS, max(1, msb_index(b_masked) + 1))`.
- With accept at edge t0, STEP occupies the cycles after edges t0 .. t0+S-1.
- FINISH occupies the cycle after edge t0+S.
- `out_valid` rises after edge t0+S+1.

**Throughput**
- One result per S+3 cycles when `out_ready` is held at 1: S STEP + FINISH + DONE + IDLE.

**ALU path**
- The ALU is combinational; each control word is captured in the same cycle it is driven.

## Test plan

1. `a=3`, `b=5`, `out_ready=1`:
   - S=3; `out_valid` high 4 edges after accept.
   - `product=0x000F`, `zr=0`, `ng=0`.
   - STEP control words in order: 000010, 001100, 000010.
2. `a=0x0011`, `b=0x0003`: `product=0x0033`, `zr=0`, `ng=0`, S=2.
3. Zero and overflow cases:
   - `b=0`, `a=0x1234`: S=1, `product=0`, `zr=1`.
   - `a=0x0100`, `b=0x0100`: `product=0x0000` (wrap), `zr=1`, `ng=0`.
4. `a=0xFFFF`, `b=0x0002`: `product=0xFFFE`, `zr=0`, `ng=1`.
5. Backpressure and busy handling:
   - Hold `out_ready=0` for 5 cycles in DONE: `out_valid`, `product` and flags stay stable.
   - Pulse `in_valid` with `a=7`, `b=7` while busy: ignored; the first result is unchanged.
   - Raise `out_ready`: IDLE, then the next accept works.
6. Reset cases:
   - Assert `reset` for 1 cycle during STEP of `a=3`, `b=0x8000`: `out_valid` never asserts, `in_ready=1` after reset, all outputs at reset values.
   - With `N_BITS=4`, `b=0x0012`: treated as `b=2`, S=2.

Source files
------------

// File: rtl/hack_alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hack_alu_mul_ctrl
//  Purpose  : Shift-and-add 16x16 -> 16 multiplier controller that borrows
//             an external combinational Hack ALU for every addition, one
//             ALU control word per cycle, with valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module hack_alu_mul_ctrl #(
    parameter int N_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);

    // Controller states
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Hack ALU control words {zx,nx,zy,ny,f,no}
    localparam logic [5:0] C_CTRL_ADD   = 6'b000010;  // x + y
    localparam logic [5:0] C_CTRL_PASSX = 6'b001100;  // x
    localparam logic [5:0] C_CTRL_ZERO  = 6'b101010;  // constant 0

    // Multiplier bits above N_BITS-1 are discarded on accept
    localparam logic [15:0] C_MASK = 16'hFFFF >> (16 - N_BITS);
    localparam logic [4:0]  C_LAST = 5'(N_BITS - 1);

    logic [1:0]  r_state;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [4:0]  r_cnt;
    logic [15:0] r_product;
    logic        r_zr;
    logic        r_ng;

    logic [15:0] w_mplier_next;
    logic        w_step_last;
    logic [5:0]  w_ctrl;
    logic        w_accept;

    assign w_mplier_next = r_mplier >> 1;
    // Stop once no set multiplier bits remain, or the bit budget is spent
    assign w_step_last   = (w_mplier_next == 16'd0) || (r_cnt == C_LAST);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;

    assign product = r_product;
    assign zr      = r_zr;
    assign ng      = r_ng;

    // ALU operand and control drive, decoded from the current state
    always_comb begin
        alu_x  = 16'd0;
        alu_y  = 16'd0;
        w_ctrl = C_CTRL_ZERO;
        case (r_state)
            S_STEP: begin
                alu_x  = r_acc;
                alu_y  = r_mcand;
                w_ctrl = r_mplier[0] ? C_CTRL_ADD : C_CTRL_PASSX;
            end
            S_FINISH: begin
                alu_x  = r_acc;
                alu_y  = 16'd0;
                w_ctrl = C_CTRL_PASSX;
            end
            default: begin
                alu_x  = 16'd0;
                alu_y  = 16'd0;
                w_ctrl = C_CTRL_ZERO;
            end
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = w_ctrl;

    // State machine plus datapath registers; the ALU result is captured the
    // same cycle its control word is driven
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= 16'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 16'd0;
            r_cnt     <= 5'd0;
            r_product <= 16'd0;
            r_zr      <= 1'b0;
            r_ng      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc    <= 16'd0;
                        r_mcand  <= a;
                        r_mplier <= b & C_MASK;
                        r_cnt    <= 5'd0;
                        r_state  <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_acc    <= alu_out;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_step_last) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_product <= alu_out;
                    r_zr      <= alu_zr;
                    r_ng      <= alu_ng;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_alu_mul_ctrl
//  Purpose  : Self-checking bench for hack_alu_mul_ctrl with a behavioural
//             Hack ALU, an arithmetic reference model and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hack_alu_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, product;
    logic        zr, ng;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

    // Second instance with a narrowed multiplier width
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] a4, b4, product4;
    logic        zr4, ng4;
    logic [15:0] alu_x4, alu_y4, alu_out4;
    logic        alu_zx4, alu_nx4, alu_zy4, alu_ny4, alu_f4, alu_no4, alu_zr4, alu_ng4;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] p;
        logic        zr;
        logic        ng;
        int          s;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Hack ALU: returns {out, zr, ng}
    function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'd0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'd0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? (xx + yy) : (xx & yy);
        o  = c[0] ? ~o : o;
        return {o, (o == 16'd0), o[15]};
    endfunction

    assign {alu_out, alu_zr, alu_ng} =
        hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign {alu_out4, alu_zr4, alu_ng4} =
        hack_alu(alu_x4, alu_y4, {alu_zx4, alu_nx4, alu_zy4, alu_ny4, alu_f4, alu_no4});

    hack_alu_mul_ctrl #(.N_BITS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .zr(zr), .ng(ng), .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
        .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    hack_alu_mul_ctrl #(.N_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .zr(zr4), .ng(ng4), .alu_x(alu_x4), .alu_y(alu_y4),
        .alu_zx(alu_zx4), .alu_nx(alu_nx4), .alu_zy(alu_zy4), .alu_ny(alu_ny4),
        .alu_f(alu_f4), .alu_no(alu_no4), .alu_out(alu_out4),
        .alu_zr(alu_zr4), .alu_ng(alu_ng4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: low 16 bits of the product, flags and STEP count
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input int nb);
        exp_t e;
        logic [31:0] full;
        logic [15:0] bm;
        int msb;
        bm   = (nb >= 16) ? mb : (mb & 16'((32'd1 << nb) - 1));
        full = 32'(ma) * 32'(bm);
        e.p  = full[15:0];
        e.zr = (e.p == 16'd0);
        e.ng = e.p[15];
        msb  = -1;
        for (int i = 0; i < 16; i++) if (bm[i]) msb = i;
        e.s  = (msb + 1 < 1) ? 1 : msb + 1;
        if (e.s > nb) e.s = nb;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Issue one operand pair; returns just after the accepting edge
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
        exp_t e;
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ia;
        b = ib;
        if (in_ready) begin
            e = model(ia, ib, 16);
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Let the scoreboard empty, optionally with random back-pressure
    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        out_ready = 1'b1;
    endtask

    // Monitor: latency on out_valid rise, result compare on each handshake
    initial begin
        exp_t e;
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
                    if (sb.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
                    else check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].s + 1));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("product", 32'(product), 32'(e.p));
                    check("zr", 32'(zr), 32'(e.zr));
                    check("ng", 32'(ng), 32'(e.ng));
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [5:0]  ctrl;
        logic [15:0] ra, rb;
        exp_t        e;
        int          n;
        bit          ok;

        reset = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'({product, zr, ng}), 32'd0);
        ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        check("idle_alu_ctrl", 32'(ctrl), 32'b101010);
        check("idle_alu_xy", 32'({alu_x, alu_y}), 32'd0);

        // 3*5: control-word sequence follows the multiplier bits
        issue(16'd3, 16'd5);
        rb = 16'd5;
        for (int i = 0; i < 3; i++) begin
            ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
            check("step_ctrl", 32'(ctrl), rb[i] ? 32'b000010 : 32'b001100);
            if (i == 0) check("step0_alu_y", 32'(alu_y), 32'd3);
            @(posedge clk); #1;
        end
        ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        check("finish_ctrl", 32'(ctrl), 32'b001100);
        check("finish_alu_y", 32'(alu_y), 32'd0);
        drain(1'b0);

        // Directed operand pairs from the plan
        issue(16'h0011, 16'h0003); drain(1'b0);
        issue(16'h1234, 16'h0000); drain(1'b0);
        issue(16'h0100, 16'h0100); drain(1'b0);
        issue(16'hFFFF, 16'h0002); drain(1'b0);

        // Back-pressure and busy-time input
        out_ready = 1'b0;
        issue(16'h0102, 16'h0305);
        e = model(16'h0102, 16'h0305, 16);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; a = 16'd7; b = 16'd7;
                if (in_ready) ok = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (!(out_valid && product == e.p && zr == e.zr && ng == e.ng)) ok = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("hold_stable", 32'(ok), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_accept", 32'(in_ready), 32'd1);
        check("sb_empty_after_hold", 32'(sb.size()), 32'd0);

        // Randomized traffic with random back-pressure
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) & (16'hFFFF >> $urandom_range(0, 15));
            issue(ra, rb);
            drain(1'b1);
        end

        // Reset during STEP: operation abandoned, no result
        issue(16'd3, 16'h8000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_outs", 32'({out_valid, product, zr, ng}), 32'd0);
        ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        check("midrst_alu", 32'({ctrl, alu_x, alu_y} != 38'b101010 << 32), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (out_valid !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("midrst_no_result", 32'(ok), 32'd1);

        // Narrow instance: high multiplier bits ignored
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? 16'd5 : 16'h1234;
            rb = (k == 0) ? 16'h0012 : 16'hFFFF;
            e = model(ra, rb, 4);
            in_valid4 = 1'b1; a4 = ra; b4 = rb;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            n = 0;
            while (!out_valid4 && n < 40) begin
                @(posedge clk); #1; n++;
            end
            check("n4_latency", 32'(n), 32'(e.s + 1));
            check("n4_product", 32'({product4, zr4, ng4}), 32'({e.p, e.zr, e.ng}));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
